// File: rtl/drive_pkg.sv
// drive_pkg: shared command-word layout, opcodes and scheduler state encoding
// used by seek_scheduler and its delta calculator.
package drive_pkg;

  localparam int unsigned NUM_CYL_DEF = 512;

  localparam logic [2:0] OP_SEEK  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;

  // Seek word layout: [15:13] opcode, [12:11] zero, [10] head, [9] dir, [8:0] delta
  localparam int unsigned HEAD_BIT  = 10;
  localparam int unsigned DIR_BIT   = 9;
  localparam int unsigned DELTA_MSB = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLocate,
    StCalc,
    StIssueSeek,
    StSettle,
    StVerify,
    StXferCmd,
    StXferSec,
    StDone,
    StError
  } sched_state_e;

  function automatic logic [15:0] seek_word(input logic head, input logic dir,
                                            input logic [DELTA_MSB:0] delta);
    logic [15:0] w;
    w                = '0;
    w[15:13]         = OP_SEEK;
    w[HEAD_BIT]      = head;
    w[DIR_BIT]       = dir;
    w[DELTA_MSB:0]   = delta;
    return w;
  endfunction

endpackage

// File: rtl/seek_scheduler_delta.sv
// seek_delta_calc: registered distance/direction between target (a) and current (b)
// cylinder. Fed with next-state values so the result lines up with the CALC cycle.
module seek_delta_calc #(
  parameter int unsigned CYL_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CYL_W-1:0] a_i,
  input  logic [CYL_W-1:0] b_i,
  output logic [CYL_W-1:0] delta_o,
  output logic             dir_o,
  output logic             zero_o
);

  logic [CYL_W-1:0] delta_q;
  logic             dir_q;
  logic             zero_q;

  // Register |a-b|, a>b and a==b every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      delta_q <= (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);
      dir_q   <= (a_i > b_i);
      zero_q  <= (a_i == b_i);
    end
  end

  assign delta_o = delta_q;
  assign dir_o   = dir_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/seek_scheduler.sv
// seek_scheduler: turns host seek/write requests into driveControl command words,
// locating the head from the header decoder, verifying arrival and retrying.
// Optional feature: define SEEK_SCHED_CYL_CACHE_EN to reuse the last verified
// cylinder/head so the next request skips LOCATE.
module seek_scheduler
  import drive_pkg::*;
#(
  parameter int unsigned NUM_CYL     = NUM_CYL_DEF,
  parameter int unsigned CYL_W       = 9,
  parameter int unsigned HDR_TIMEOUT = 1 << 20,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CYL_W-1:0] req_cyl,
  input  logic             req_head,
  input  logic             req_write,
  input  logic [5:0]       req_sector,
  input  logic [CYL_W-1:0] cylNumIn,
  input  logic             cylNumInReady,
  input  logic             headNumIn,
  input  logic             headNumInReady,
  input  logic             drive_ready,
  output logic [15:0]      cmd_word,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned TmrW   = $clog2(HDR_TIMEOUT + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
  localparam int unsigned CylW1  = CYL_W + 1;
  localparam int unsigned DeltaW = DELTA_MSB + 1;

  localparam logic [TmrW-1:0]   TmrLast   = TmrW'(HDR_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
  localparam logic [CYL_W:0]    NumCylLim = CylW1'(NUM_CYL);

  sched_state_e      state_q, state_d;
  logic              ready_q;
  logic [CYL_W-1:0]  tgt_cyl_q, tgt_cyl_d;
  logic              tgt_head_q, tgt_head_d;
  logic              write_q, write_d;
  logic [5:0]        sector_q, sector_d;
  logic [CYL_W-1:0]  cur_cyl_q, cur_cyl_d;
  logic              cur_head_q, cur_head_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              seen_low_q, seen_low_d;
  logic              timed;
  logic              tmr_last;
  logic              head_eff;
  logic              hdr_match;
  logic [CYL_W-1:0]  calc_delta;
  logic              calc_dir;
  logic              calc_zero;

`ifdef SEEK_SCHED_CYL_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
`endif

  seek_delta_calc #(
    .CYL_W (CYL_W)
  ) u_delta (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (tgt_cyl_d),
    .b_i     (cur_cyl_d),
    .delta_o (calc_delta),
    .dir_o   (calc_dir),
    .zero_o  (calc_zero)
  );

  assign req_ready = ready_q && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tmr_last  = (tmr_q == TmrLast);
  // A cylinder strobe without a head strobe keeps the head we already know.
  assign head_eff  = headNumInReady ? headNumIn : cur_head_q;
  assign hdr_match = (cylNumIn == tgt_cyl_q) && (head_eff == tgt_head_q);

  // Next-state logic and command/status outputs.
  always_comb begin
    state_d    = state_q;
    tgt_cyl_d  = tgt_cyl_q;
    tgt_head_d = tgt_head_q;
    write_d    = write_q;
    sector_d   = sector_q;
    cur_cyl_d  = cur_cyl_q;
    cur_head_d = cur_head_q;
    retry_d    = retry_q;
    seen_low_d = seen_low_q;
`ifdef SEEK_SCHED_CYL_CACHE_EN
    cache_valid_d = cache_valid_q;
`endif
    timed      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_word   = '0;
    done       = 1'b0;
    error      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          tgt_cyl_d  = req_cyl;
          tgt_head_d = req_head;
          write_d    = req_write;
          sector_d   = req_sector;
          retry_d    = '0;
          if ({1'b0, req_cyl} >= NumCylLim) begin
            state_d = StError;
`ifdef SEEK_SCHED_CYL_CACHE_EN
          end else if (cache_valid_q) begin
            state_d = StCalc;
`endif
          end else begin
            state_d = StLocate;
          end
        end
      end
      StLocate: begin
        timed = 1'b1;
        if (cylNumInReady) begin
          cur_cyl_d  = cylNumIn;
          cur_head_d = head_eff;
          state_d    = StCalc;
        end else begin
          if (headNumInReady) cur_head_d = headNumIn;
          if (tmr_last) state_d = StError;
        end
      end
      StCalc: begin
        // Same cylinder and head: nothing to move, just confirm position.
        if (calc_zero && (cur_head_q == tgt_head_q)) state_d = StVerify;
        else                                         state_d = StIssueSeek;
      end
      StIssueSeek: begin
        cmd_valid = 1'b1;
        cmd_word  = seek_word(tgt_head_q, calc_dir, DeltaW'(calc_delta));
        if (cmd_ready) begin
          seen_low_d = 1'b0;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        // Settled once drive_ready goes low then high, or stays high for the full window.
        timed = 1'b1;
        if (!drive_ready) seen_low_d = 1'b1;
        if (drive_ready && (seen_low_q || tmr_last)) state_d = StVerify;
        else if (tmr_last)                           state_d = StError;
      end
      StVerify: begin
        timed = 1'b1;
        if (cylNumInReady) begin
          cur_cyl_d  = cylNumIn;
          cur_head_d = head_eff;
          if (hdr_match) begin
`ifdef SEEK_SCHED_CYL_CACHE_EN
            cache_valid_d = 1'b1;
`endif
            state_d = write_q ? StXferCmd : StDone;
          end else if (retry_q == RetryMax) begin
            state_d = StError;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StCalc;
          end
        end else begin
          if (headNumInReady) cur_head_d = headNumIn;
          if (tmr_last) state_d = StError;
        end
      end
      StXferCmd: begin
        cmd_valid = 1'b1;
        cmd_word  = {OP_WRITE, 13'b0};
        if (cmd_ready) state_d = StXferSec;
      end
      StXferSec: begin
        cmd_valid = 1'b1;
        cmd_word  = {10'b0, sector_q};
        if (cmd_ready) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StError: begin
        error   = 1'b1;
`ifdef SEEK_SCHED_CYL_CACHE_EN
        cache_valid_d = 1'b0;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Timer restarts on every state change.
    tmr_d = (timed && (state_d == state_q)) ? tmr_q + 1'b1 : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      tgt_cyl_q  <= '0;
      tgt_head_q <= 1'b0;
      write_q    <= 1'b0;
      sector_q   <= '0;
      cur_cyl_q  <= '0;
      cur_head_q <= 1'b0;
      retry_q    <= '0;
      tmr_q      <= '0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      tgt_cyl_q  <= tgt_cyl_d;
      tgt_head_q <= tgt_head_d;
      write_q    <= write_d;
      sector_q   <= sector_d;
      cur_cyl_q  <= cur_cyl_d;
      cur_head_q <= cur_head_d;
      retry_q    <= retry_d;
      tmr_q      <= tmr_d;
      seen_low_q <= seen_low_d;
    end
  end

`ifdef SEEK_SCHED_CYL_CACHE_EN
  // Validity of the cached position held in cur_cyl_q/cur_head_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cache_valid_q <= 1'b0;
    else        cache_valid_q <= cache_valid_d;
  end
`endif

endmodule

// File: tb/tb_seek_scheduler.sv
// tb_seek_scheduler: directed vectors plus hand-written sequences for seek_scheduler.
module tb_seek_scheduler;

  localparam int unsigned NUM_CYL     = 400;
  localparam int unsigned CYL_W       = 9;
  localparam int unsigned HDR_TIMEOUT = 64;
  localparam int unsigned MAX_RETRY   = 3;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_head, req_write;
  logic [8:0]  req_cyl, cylNumIn;
  logic [5:0]  req_sector;
  logic        cylNumInReady, headNumIn, headNumInReady, drive_ready;
  logic [15:0] cmd_word;
  logic        cmd_valid, cmd_ready, busy, done, error;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] words[$];

  typedef struct {
    string       name;
    logic [8:0]  cur_cyl;
    logic        cur_head;
    logic [8:0]  cyl;
    logic        head;
    logic        wr;
    logic [5:0]  sector;
    logic        seek;
    logic        slow;
    logic        bad;
    int          nwords;
    logic [15:0] w0, w1, w2;
  } vec_t;

  vec_t vecs[8];

  seek_scheduler #(
    .NUM_CYL     (NUM_CYL),
    .CYL_W       (CYL_W),
    .HDR_TIMEOUT (HDR_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cyl        (req_cyl),
    .req_head       (req_head),
    .req_write      (req_write),
    .req_sector     (req_sector),
    .cylNumIn       (cylNumIn),
    .cylNumInReady  (cylNumInReady),
    .headNumIn      (headNumIn),
    .headNumInReady (headNumInReady),
    .drive_ready    (drive_ready),
    .cmd_word       (cmd_word),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record transferred words and status pulses mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) words.push_back(cmd_word);
    if (done)  done_cnt <= done_cnt + 1;
    if (error) err_cnt  <= err_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  function automatic vec_t mk(input string n, input int cc, input logic ch, input int c,
                              input logic h, input logic w, input int s, input logic sk,
                              input logic sl, input logic bd, input int nw,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] d);
    vec_t v;
    v.name = n; v.cur_cyl = 9'(cc); v.cur_head = ch; v.cyl = 9'(c); v.head = h;
    v.wr = w; v.sector = 6'(s); v.seek = sk; v.slow = sl; v.bad = bd; v.nwords = nw;
    v.w0 = a; v.w1 = b; v.w2 = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_req(input logic [8:0] c, input logic h, input logic w,
                          input logic [5:0] s);
    int k = 0;
    while (!req_ready && k < 300) begin
      tick();
      k++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cyl = c; req_head = h; req_write = w; req_sector = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic hdr(input logic [8:0] c, input logic h);
    cylNumIn = c; headNumIn = h; cylNumInReady = 1'b1; headNumInReady = 1'b1;
    tick();
    cylNumInReady = 1'b0; headNumInReady = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (words.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic settle();
    drive_ready = 1'b0;
    tick();
    tick();
    drive_ready = 1'b1;
    tick();
  endtask

  // Clears any cached position so the next request goes through LOCATE.
  task automatic invalidate();
`ifdef SEEK_SCHED_CYL_CACHE_EN
    send_req(9'd511, 1'b0, 1'b0, 6'd0);
    repeat (3) tick();
`endif
  endtask

  function automatic logic [15:0] word_at(input int j);
    return (j < words.size()) ? words[j] : 16'hdead;
  endfunction

  initial begin
    int d0, e0, k, bad;
    logic [15:0] exp_w;

    vecs[0] = mk("seek_up_read",  100, 0, 250, 0, 0,  0, 1, 0, 0, 1, 16'h2296, 16'h0, 16'h0);
    vecs[1] = mk("seek_dn_write", 300, 0,  40, 1, 1,  7, 1, 0, 0, 3, 16'h2504, 16'h4000,
                 16'h0007);
    vecs[2] = mk("no_seek",        77, 0,  77, 0, 0,  0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    vecs[3] = mk("head_only",      77, 0,  77, 1, 0,  0, 1, 1, 0, 1, 16'h2400, 16'h0, 16'h0);
    vecs[4] = mk("full_up_write",   0, 0, 399, 1, 1, 63, 1, 0, 0, 3, 16'h278F, 16'h4000,
                 16'h003F);
    vecs[5] = mk("full_dn_read",  399, 1,   0, 1, 0,  0, 1, 0, 0, 1, 16'h258F, 16'h0, 16'h0);
    vecs[6] = mk("bad_cyl_400",     0, 0, 400, 0, 0,  0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
    vecs[7] = mk("bad_cyl_511",     0, 0, 511, 1, 1,  5, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);

    rst_n = 1'b0; req_valid = 1'b0; req_cyl = '0; req_head = 1'b0; req_write = 1'b0;
    req_sector = '0; cylNumIn = '0; cylNumInReady = 1'b0; headNumIn = 1'b0;
    headNumInReady = 1'b0; drive_ready = 1'b1; cmd_ready = 1'b1;

    // Reset state
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_word",  32'(cmd_word),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_ready_before_clk", 32'(req_ready), 32'd0);
    tick();
    check("ready_after_clk", 32'(req_ready), 32'd1);

    // Table-driven requests
    for (int i = 0; i < 8; i++) begin
      invalidate();
      words.delete();
      d0 = done_cnt; e0 = err_cnt;
      send_req(vecs[i].cyl, vecs[i].head, vecs[i].wr, vecs[i].sector);
      if (vecs[i].bad) begin
        repeat (3) tick();
      end else begin
        hdr(vecs[i].cur_cyl, vecs[i].cur_head);
        if (vecs[i].seek) begin
          wait_words(1, 20);
          if (vecs[i].slow) repeat (HDR_TIMEOUT + 4) tick();
          else settle();
        end else begin
          tick();
        end
        hdr(vecs[i].cyl, vecs[i].head);
        wait_done(d0, 20);
        tick();
      end
      check({vecs[i].name, "_nwords"}, 32'(words.size()), 32'(vecs[i].nwords));
      for (int j = 0; j < vecs[i].nwords; j++) begin
        exp_w = (j == 0) ? vecs[i].w0 : (j == 1) ? vecs[i].w1 : vecs[i].w2;
        check($sformatf("%s_word%0d", vecs[i].name, j), 32'(word_at(j)), 32'(exp_w));
      end
      check({vecs[i].name, "_done"}, 32'(done_cnt - d0), vecs[i].bad ? 32'd0 : 32'd1);
      check({vecs[i].name, "_error"}, 32'(err_cnt - e0), vecs[i].bad ? 32'd1 : 32'd0);
      check({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
    end

    // Verify keeps reading 249 for target 250: initial seek plus three re-seeks, then error
    invalidate();
    words.delete();
    d0 = done_cnt; e0 = err_cnt;
    send_req(9'd250, 1'b0, 1'b1, 6'd5);
    hdr(9'd249, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_words(i + 1, 20);
      settle();
      hdr(9'd249, 1'b0);
    end
    repeat (3) tick();
    check("retry_nwords", 32'(words.size()), 32'd4);
    for (int j = 0; j < 4; j++) check($sformatf("retry_word%0d", j), 32'(word_at(j)), 32'h2201);
    check("retry_error", 32'(err_cnt - e0), 32'd1);
    check("retry_done",  32'(done_cnt - d0), 32'd0);

    // FIFO full during the write pair: first word held, second only after it goes
    invalidate();
    words.delete();
    d0 = done_cnt;
    send_req(9'd40, 1'b1, 1'b1, 6'd7);
    hdr(9'd300, 1'b0);
    wait_words(1, 20);
    settle();
    cmd_ready = 1'b0;
    hdr(9'd40, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(cmd_valid === 1'b1 && cmd_word === 16'h4000)) bad++;
    end
    tick();
    cmd_ready = 1'b1;
    wait_done(d0, 10);
    check("stall_hold_deviations", 32'(bad), 32'd0);
    check("stall_nwords", 32'(words.size()), 32'd3);
    check("stall_word0", 32'(word_at(0)), 32'h2504);
    check("stall_word1", 32'(word_at(1)), 32'h4000);
    check("stall_word2", 32'(word_at(2)), 32'h0007);
    check("stall_done",  32'(done_cnt - d0), 32'd1);

    // No header while locating
    invalidate();
    words.delete();
    d0 = done_cnt; e0 = err_cnt;
    send_req(9'd250, 1'b0, 1'b0, 6'd0);
    k = 0;
    while (err_cnt == e0 && k < 200) begin
      tick();
      k++;
    end
    check("locate_timeout_error", 32'(err_cnt - e0), 32'd1);
    check("locate_timeout_window", 32'(k >= 64 && k <= 66), 32'd1);
    check("locate_timeout_nwords", 32'(words.size()), 32'd0);
    tick();
    check("locate_timeout_idle", 32'(busy), 32'd0);

    // Head strobe alone updates head; a later cylinder-only strobe keeps it
    invalidate();
    words.delete();
    d0 = done_cnt;
    send_req(9'd77, 1'b1, 1'b0, 6'd0);
    headNumIn = 1'b1; headNumInReady = 1'b1;
    tick();
    headNumInReady = 1'b0; headNumIn = 1'b0;
    cylNumIn = 9'd77; cylNumInReady = 1'b1;
    tick();
    cylNumInReady = 1'b0;
    tick();
    hdr(9'd77, 1'b1);
    wait_done(d0, 20);
    check("head_alone_nwords", 32'(words.size()), 32'd0);
    check("head_alone_done",   32'(done_cnt - d0), 32'd1);

`ifdef SEEK_SCHED_CYL_CACHE_EN
    // Second request after a verified 250 seeks straight away
    invalidate();
    words.delete();
    d0 = done_cnt;
    send_req(9'd250, 1'b0, 1'b0, 6'd0);
    hdr(9'd100, 1'b0);
    wait_words(1, 20);
    settle();
    hdr(9'd250, 1'b0);
    wait_done(d0, 20);
    tick();
    words.delete();
    d0 = done_cnt;
    send_req(9'd260, 1'b0, 1'b0, 6'd0);
    wait_words(1, 4);
    check("cache_nwords", 32'(words.size()), 32'd1);
    check("cache_word0",  32'(word_at(0)), 32'h220A);
    settle();
    hdr(9'd260, 1'b0);
    wait_done(d0, 20);
    check("cache_done", 32'(done_cnt - d0), 32'd1);
`endif

    // Reset while a seek word is waiting on the FIFO
    invalidate();
    words.delete();
    cmd_ready = 1'b0;
    send_req(9'd250, 1'b0, 1'b0, 6'd0);
    hdr(9'd100, 1'b0);
    tick();
    check("pre_reset_cmd_valid", 32'(cmd_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("reset_issue_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset_issue_cmd_word",  32'(cmd_word),  32'd0);
    check("reset_issue_busy",      32'(busy),      32'd0);
    check("reset_issue_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick();

    // Reset while settling
    words.delete();
    send_req(9'd250, 1'b0, 1'b0, 6'd0);
    hdr(9'd100, 1'b0);
    wait_words(1, 20);
    repeat (3) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("reset_settle_busy",      32'(busy),      32'd0);
    check("reset_settle_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset_settle_done",      32'(done),      32'd0);
    check("reset_settle_error",     32'(error),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
